// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue with branch delay-slot trimming and flush.
// Define IF_ID_QUEUE_BYPASS_EN to let a push into an empty queue reach ID in one cycle.
module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int EXC_W  = 32
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic [PC_W-1:0]            postif_pc_i,
  input  logic [INST_W-1:0]          postif_inst_i,
  input  logic [EXC_W-1:0]           postif_exception_type_i,
  input  logic                       postif_inst_valid_i,
  output logic                       postif_ready_o,
  input  logic                       branch_enable_i,
  input  logic                       exception_i,
  input  logic [3:0]                 stall_i,
  output logic [PC_W-1:0]            id_pc_o,
  output logic [INST_W-1:0]          id_inst_o,
  output logic [EXC_W-1:0]           id_exception_type_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [EXC_W-1:0]  exc_mem  [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;

  logic [PC_W-1:0]   pc_nxt;
  logic [INST_W-1:0] inst_nxt;
  logic [EXC_W-1:0]  exc_nxt;

  logic id_ready, empty, push_req, bypass, trim, do_push, do_pop;
  logic unused_stall;

  // stall_i[0] is the fetch-side stall; it never gates the queue
  assign unused_stall = stall_i[0];
  assign id_ready     = (stall_i[3:1] == 3'b000);
  assign empty        = (count == '0);
  assign postif_ready_o = (count != FULL_CNT);
  assign push_req     = postif_inst_valid_i && postif_ready_o;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign bypass = push_req && empty && id_ready && !branch_enable_i && !exception_i;
`else
  assign bypass = 1'b0;
`endif

  // A branch with a non-empty queue keeps only the head (the delay slot)
  assign trim    = branch_enable_i && !empty && !exception_i;
  assign do_push = push_req && !exception_i && !trim && !bypass;
  assign do_pop  = id_ready && !empty && !exception_i;

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    if (exception_i) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (do_pop)
        rd_ptr_nxt = rd_ptr + PTR_W'(1);
      if (trim) begin
        wr_ptr_nxt = rd_ptr + PTR_W'(1);
        count_nxt  = do_pop ? '0 : CNT_W'(1);
      end else begin
        if (do_push)
          wr_ptr_nxt = wr_ptr + PTR_W'(1);
        count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
    end
  end

  always_comb begin
    pc_nxt   = id_pc_o;
    inst_nxt = id_inst_o;
    exc_nxt  = id_exception_type_o;
    if (exception_i) begin
      pc_nxt   = '0;
      inst_nxt = '0;
      exc_nxt  = '0;
    end else if (id_ready) begin
      if (!empty) begin
        pc_nxt   = pc_mem[rd_ptr];
        inst_nxt = inst_mem[rd_ptr];
        exc_nxt  = exc_mem[rd_ptr];
      end else if (bypass) begin
        pc_nxt   = postif_pc_i;
        inst_nxt = postif_inst_i;
        exc_nxt  = postif_exception_type_i;
      end else begin
        pc_nxt   = '0;
        inst_nxt = '0;
        exc_nxt  = '0;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_ptr              <= '0;
      wr_ptr              <= '0;
      count               <= '0;
      id_pc_o             <= '0;
      id_inst_o           <= '0;
      id_exception_type_o <= '0;
    end else begin
      rd_ptr              <= rd_ptr_nxt;
      wr_ptr              <= wr_ptr_nxt;
      count               <= count_nxt;
      id_pc_o             <= pc_nxt;
      id_inst_o           <= inst_nxt;
      id_exception_type_o <= exc_nxt;
    end
  end

  // Storage needs no reset: only slots counted as occupied are ever read
  always_ff @(posedge clock_i) begin
    if (do_push) begin
      pc_mem[wr_ptr]   <= postif_pc_i;
      inst_mem[wr_ptr] <= postif_inst_i;
      exc_mem[wr_ptr]  <= postif_exception_type_i;
    end
  end

  assign count_o = count;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue; a behavioural queue acts as scoreboard for every output.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);
`ifdef IF_ID_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clock_i;
  logic             reset_i;
  logic [31:0]      postif_pc_i;
  logic [31:0]      postif_inst_i;
  logic [31:0]      postif_exception_type_i;
  logic             postif_inst_valid_i;
  logic             postif_ready_o;
  logic             branch_enable_i;
  logic             exception_i;
  logic [3:0]       stall_i;
  logic [31:0]      id_pc_o;
  logic [31:0]      id_inst_o;
  logic [31:0]      id_exception_type_o;
  logic [CNT_W-1:0] count_o;

  if_id_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32), .EXC_W(32)) dut (
    .clock_i                 (clock_i),
    .reset_i                 (reset_i),
    .postif_pc_i             (postif_pc_i),
    .postif_inst_i           (postif_inst_i),
    .postif_exception_type_i (postif_exception_type_i),
    .postif_inst_valid_i     (postif_inst_valid_i),
    .postif_ready_o          (postif_ready_o),
    .branch_enable_i         (branch_enable_i),
    .exception_i             (exception_i),
    .stall_i                 (stall_i),
    .id_pc_o                 (id_pc_o),
    .id_inst_o               (id_inst_o),
    .id_exception_type_o     (id_exception_type_o),
    .count_o                 (count_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_q [$];
  logic [31:0] model_out = '0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return (pc == 32'h0) ? 32'h0 : {pc[15:0], ~pc[15:0]};
  endfunction

  function automatic logic [31:0] exc_of(input logic [31:0] pc);
    return (pc == 32'h0) ? 32'h0 : ({24'h0, pc[7:0]} ^ 32'h8000_0001);
  endfunction

  // Reference behaviour for one clock, evaluated on the pre-edge state
  task automatic modelStep(input logic valid, input logic [31:0] pc, input logic [3:0] stall,
                           input logic branch, input logic exc);
    bit accept, idr, byp;
    logic [31:0] keep;
    accept = valid && (model_q.size() < DEPTH);
    idr    = (stall[3:1] == 3'b000);
    if (exc) begin
      model_q.delete();
      model_out = '0;
    end else begin
      byp = BYPASS && accept && (model_q.size() == 0) && idr && !branch;
      if (branch && model_q.size() > 0) begin
        keep = model_q[0];
        model_q.delete();
        model_q.push_back(keep);
        accept = 1'b0;
      end
      if (idr) begin
        if (model_q.size() > 0) model_out = model_q.pop_front();
        else if (byp)           model_out = pc;
        else                    model_out = '0;
      end
      if (accept && !byp) model_q.push_back(pc);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [CNT_W-1:0] exp_count;
    logic             exp_ready;
    exp_count = CNT_W'(model_q.size());
    exp_ready = (model_q.size() < DEPTH);
    checks++;
    assert (id_pc_o === model_out) else begin
      failures++;
      $error("[TB] FAIL %s id_pc: got %h expected %h", tag, id_pc_o, model_out);
    end
    checks++;
    assert (id_inst_o === inst_of(model_out)) else begin
      failures++;
      $error("[TB] FAIL %s id_inst: got %h expected %h", tag, id_inst_o, inst_of(model_out));
    end
    checks++;
    assert (id_exception_type_o === exc_of(model_out)) else begin
      failures++;
      $error("[TB] FAIL %s id_exc: got %h expected %h", tag, id_exception_type_o, exc_of(model_out));
    end
    checks++;
    assert (count_o === exp_count) else begin
      failures++;
      $error("[TB] FAIL %s count: got %0d expected %0d", tag, count_o, exp_count);
    end
    checks++;
    assert (postif_ready_o === exp_ready) else begin
      failures++;
      $error("[TB] FAIL %s ready: got %b expected %b", tag, postif_ready_o, exp_ready);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [3:0] stall,
                               input logic branch, input logic exc, input string tag);
    @(negedge clock_i);
    postif_inst_valid_i     = valid;
    postif_pc_i             = pc;
    postif_inst_i           = inst_of(pc);
    postif_exception_type_i = exc_of(pc);
    stall_i                 = stall;
    branch_enable_i         = branch;
    exception_i             = exc;
    modelStep(valid, pc, stall, branch, exc);
    @(posedge clock_i);
    #1;
    checkOutput(tag);
  endtask

  task automatic setIdle();
    postif_inst_valid_i     = 1'b0;
    postif_pc_i             = '0;
    postif_inst_i           = '0;
    postif_exception_type_i = '0;
    stall_i                 = 4'b0000;
    branch_enable_i         = 1'b0;
    exception_i             = 1'b0;
  endtask

  initial begin
    reset_i = 1'b0;
    setIdle();
    #12;
    checkOutput("reset_state");
    @(negedge clock_i);
    reset_i = 1'b1;

    $display("[TB] fill while ID stalled, then drain");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 32'h100 + 32'(4*i), 4'b0010 << (i % 3), 1'b0, 1'b0, "fill");
    applyStimulus(1'b1, 32'h110, 4'b0010, 1'b0, 1'b0, "push_when_full");
    applyStimulus(1'b0, 32'h0, 4'b0001, 1'b0, 1'b0, "drain_inst_stall");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, "drain");

    $display("[TB] continuous streaming");
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 32'h400 + 32'(4*i), 4'b0000, 1'b0, 1'b0, "stream");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, "stream_tail");

    $display("[TB] branch trims younger entries");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h200 + 32'(4*i), 4'b0010, 1'b0, 1'b0, "br_fill");
    applyStimulus(1'b1, 32'h20C, 4'b0010, 1'b1, 1'b0, "br_trim_stalled");
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, "br_delay_slot");
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, "br_after");

    $display("[TB] branch with empty queue keeps the push");
    applyStimulus(1'b1, 32'h300, 4'b0000, 1'b1, 1'b0, "br_empty_push");
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, "br_empty_deliver");
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, "br_empty_after");

    $display("[TB] branch with ID ready pops the delay slot");
    applyStimulus(1'b1, 32'h500, 4'b0010, 1'b0, 1'b0, "br_ready_fill");
    applyStimulus(1'b1, 32'h504, 4'b1000, 1'b0, 1'b0, "br_ready_fill");
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0, "br_ready_pop");
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, "br_ready_after");

    $display("[TB] exception flush");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h600 + 32'(4*i), 4'b0100, 1'b0, 1'b0, "exc_fill");
    applyStimulus(1'b1, 32'h60C, 4'b0000, 1'b1, 1'b1, "exc_flush");
    applyStimulus(1'b1, 32'h610, 4'b0000, 1'b0, 1'b0, "exc_resume");
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, "exc_resume_out");
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, "exc_resume_idle");

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(1'b1, 32'h700, 4'b0000, 1'b0, 1'b0, "rst_pre");
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, "rst_pre_out");
    applyStimulus(1'b1, 32'h704, 4'b0010, 1'b0, 1'b0, "rst_pre_fill");
    applyStimulus(1'b1, 32'h708, 4'b0010, 1'b0, 1'b0, "rst_pre_fill");
    #2;
    setIdle();
    reset_i = 1'b0;
    model_q.delete();
    model_out = '0;
    #1;
    checkOutput("async_reset");
    @(negedge clock_i);
    reset_i = 1'b1;
    applyStimulus(1'b1, 32'h800, 4'b0000, 1'b0, 1'b0, "post_reset_push");
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, "post_reset_out");
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, "post_reset_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter PC_W, default 32, PC width.
REQ-003 SHALL have parameter INST_W, default 32, instruction width.
REQ-004 SHALL have parameter EXC_W, default 32, exception-type width.
REQ-005 SHALL have port clock_i, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_i, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have port postif_pc_i, input, PC_W, fetched PC.
REQ-008 SHALL have port postif_inst_i, input, INST_W, fetched instruction.
REQ-009 SHALL have port postif_exception_type_i, input, EXC_W, fetch exception code.
REQ-010 SHALL have port postif_inst_valid_i, input, 1, fetch entry valid.
REQ-011 SHALL have port postif_ready_o, output, 1, queue can accept (= not full).
REQ-012 SHALL have port branch_enable_i, input, 1, branch resolved in ID this cycle.
REQ-013 SHALL have port exception_i, input, 1, pipeline flush.
REQ-014 SHALL have port stall_i, input, 4, {data, exe, id, inst} stall.
REQ-015 SHALL have ports id_pc_o / id_inst_o / id_exception_type_o, output, PC_W / INST_W / EXC_W, registered ID-stage entry.
REQ-016 SHALL have port count_o, output, $clog2(DEPTH+1), current occupancy.

Function
REQ-017 SHALL accept a push when postif_inst_valid_i=1 and postif_ready_o=1; postif_ready_o is derived from registered occupancy only.
REQ-018 SHALL treat ID as ready when stall_i[3:1]==0; stall_i[0] SHALL have no effect on the queue.
REQ-019 When ID is not ready, the output registers SHALL hold.
REQ-020 When ID is ready and the queue is non-empty, the head SHALL load the output registers and be popped.
REQ-021 When ID is ready and the queue is empty (and no bypass), the output registers SHALL load all-zero (bubble).
REQ-022 Push and pop in the same cycle SHALL leave count unchanged.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 count SHALL never exceed DEPTH nor underflow.
REQ-025 Entries SHALL leave the queue in push order.
REQ-026 On branch_enable_i=1 with the queue non-empty, only the head entry (delay slot) SHALL be retained; all younger entries are discarded, and any push that cycle is discarded.
REQ-027 On branch_enable_i=1 with the queue empty, a push in that same cycle SHALL be kept as the delay slot.
REQ-028 When ID is ready in a branch cycle, the retained delay slot SHALL be popped normally.
REQ-029 exception_i=1 SHALL synchronously clear the queue, pointers, count and output registers, and discard any push; it takes priority over branch, stall and push.

Reset
REQ-030 reset_i=0 SHALL asynchronously clear pointers, count, and all outputs to 0, except postif_ready_o, which SHALL be 1.
REQ-031 Reset mid-operation SHALL discard all entries; the first push after release SHALL be accepted normally.

Configuration
REQ-032 With macro IF_ID_QUEUE_BYPASS_EN defined, a push arriving while the queue is empty, ID is ready and no branch/exception occurs SHALL load the output registers directly (latency 1 cycle) without occupying a slot.
REQ-033 Without IF_ID_QUEUE_BYPASS_EN, every entry SHALL pass through the queue (push at cycle N, visible at outputs at N+2 if ID is ready).

Verification
REQ-034 Push 4 entries (pc 0x100..0x10C) with stall_i=4'b0010, then release -> outputs 0x100..0x10C on consecutive cycles; postif_ready_o=0 while count=4.
REQ-035 Push continuously with no stall -> outputs follow in order; with BYPASS_EN latency is 1 cycle, without it latency is 2 cycles; count stays <=1.
REQ-036 Queue holding pc 0x200,0x204,0x208 plus branch_enable_i=1 while ID stalled -> count=1; next output 0x200; 0x204 and 0x208 never appear.
REQ-037 Empty queue, push pc 0x300 with branch_enable_i=1 -> 0x300 is delivered to ID.
REQ-038 exception_i=1 with count=3 and a concurrent push -> next cycle count=0 and outputs=0; async reset asserted mid-stream -> all outputs zero immediately, postif_ready_o=1.
